// File: rtl/aes_round_ctrl.sv
// Sequences the AES-128 round units: ARK0, then SB/SR/MC/ARK for rounds 1..10 (MC skipped in round 10).
// Each step issues a one-cycle enable, waits for that unit's finished pulse, and drops to ERR on timeout.
module aes_round_ctrl #(
   parameter int TIMEOUT = 63
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic       abort,
   input  logic       sbytes_finished,
   input  logic       srows_finished,
   input  logic       mcols_finished,
   input  logic       ark_finished,
   output logic       sbytes_enable,
   output logic       srows_enable,
   output logic       mcols_enable,
   output logic       ark_enable,
   output logic [3:0] round,
   output logic       busy,
   output logic       done,
   output logic       err
);

   typedef enum logic [2:0] {IDLE, ARK0, SB, SR, MC, ARK, DONE, ERR} state_t;

   localparam logic [6:0] TIMEOUT_CNT = 7'(TIMEOUT);

   state_t     state, state_nxt;
   logic       issue, issue_nxt;
   logic [6:0] wait_cnt, wait_cnt_nxt;
   logic [3:0] round_nxt;
   logic       fin;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         issue    <= 1'b0;
         wait_cnt <= '0;
         round    <= '0;
      end else begin
         state    <= state_nxt;
         issue    <= issue_nxt;
         wait_cnt <= wait_cnt_nxt;
         round    <= round_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      round_nxt     = round;
      wait_cnt_nxt  = '0;
      sbytes_enable = 1'b0;
      srows_enable  = 1'b0;
      mcols_enable  = 1'b0;
      ark_enable    = 1'b0;
      done          = 1'b0;
      err           = (state == ERR);
      busy          = (state inside {ARK0, SB, SR, MC, ARK});

      // Only the active unit's completion pulse is looked at.
      fin = 1'b0;
      case (state)
         ARK0, ARK: fin = ark_finished;
         SB:        fin = sbytes_finished;
         SR:        fin = srows_finished;
         MC:        fin = mcols_finished;
         default:   fin = 1'b0;
      endcase

      case (state)
         IDLE, ERR: begin
            if (start) begin
               state_nxt = ARK0;
               round_nxt = '0;
            end
         end
         DONE: begin
            done      = 1'b1;
            state_nxt = IDLE;
            round_nxt = '0;
         end
         default: begin
            if (issue) begin
               case (state)
                  ARK0, ARK: ark_enable    = 1'b1;
                  SB:        sbytes_enable = 1'b1;
                  SR:        srows_enable  = 1'b1;
                  MC:        mcols_enable  = 1'b1;
                  default:   ;
               endcase
            end else if (fin) begin
               case (state)
                  ARK0: begin
                     round_nxt = 4'd1;
                     state_nxt = SB;
                  end
                  SB: state_nxt = SR;
                  SR: state_nxt = (round < 4'd10) ? MC : ARK;
                  MC: state_nxt = ARK;
                  ARK: begin
                     if (round < 4'd10) begin
                        round_nxt = round + 4'd1;
                        state_nxt = SB;
                     end else begin
                        state_nxt = DONE;
                     end
                  end
                  default: ;
               endcase
            end else begin
               wait_cnt_nxt = wait_cnt + 7'd1;
               if (wait_cnt_nxt >= TIMEOUT_CNT) state_nxt = ERR;
            end
         end
      endcase

      // Abort outranks finished and timeout.
      if (abort && (state != IDLE)) begin
         state_nxt    = IDLE;
         round_nxt    = '0;
         wait_cnt_nxt = '0;
      end

      // Every entry into a step state comes from a different state, so a change marks the issue cycle.
      issue_nxt = (state_nxt != state) && (state_nxt inside {ARK0, SB, SR, MC, ARK});
   end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Bench for aes_round_ctrl: vector table, directed multi-cycle sequences, and random traffic
// against a step-list reference model.
module tb_aes_round_ctrl;

   localparam int TIMEOUT = 63;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, abort;
   logic [3:0] man_fin, resp_fin;   // bit 0 sb, 1 sr, 2 mc, 3 ark
   logic       auto_resp;
   bit         withhold;
   wire  [3:0] fin = auto_resp ? resp_fin : man_fin;
   wire  [3:0] en;
   wire  [3:0] round;
   wire        busy, done, err;

   aes_round_ctrl #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort),
      .sbytes_finished(fin[0]), .srows_finished(fin[1]),
      .mcols_finished(fin[2]), .ark_finished(fin[3]),
      .sbytes_enable(en[0]), .srows_enable(en[1]),
      .mcols_enable(en[2]), .ark_enable(en[3]),
      .round(round), .busy(busy), .done(done), .err(err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [10:0] obs();
      return {en, busy, done, err, round};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Unit models: finished arrives 3 cycles after each enable.
   int cd [4];
   initial begin
      resp_fin = 4'h0;
      for (int u = 0; u < 4; u++) cd[u] = 0;
      forever begin
         @(negedge clk);
         for (int u = 0; u < 4; u++)
            if (en[u] && !(u == 0 && withhold && round == 4'd2)) cd[u] = 3;
         @(posedge clk);
         #1;
         for (int u = 0; u < 4; u++) begin
            resp_fin[u] = 1'b0;
            if (cd[u] > 0) begin
               cd[u]--;
               resp_fin[u] = (cd[u] == 0);
            end
         end
      end
   end

   // Reference model: a block is a list of 40 steps, each naming a unit and a round.
   int step_unit [40];
   int step_round[40];
   int m_mode;     // 0 idle, 1 running, 2 done, 3 error
   int m_s, m_wait;
   bit m_first;

   function automatic logic [10:0] m_out();
      logic [3:0] e;
      logic [3:0] r;
      e = 4'h0;
      r = 4'h0;
      if (m_mode == 1 && m_first) e = 4'(1 << step_unit[m_s]);
      if (m_mode == 1 || m_mode == 3) r = 4'(step_round[m_s]);
      else if (m_mode == 2) r = 4'd10;
      return {e, m_mode == 1, m_mode == 2, m_mode == 3, r};
   endfunction

   task automatic m_step();
      if (rst) m_mode = 0;
      else case (m_mode)
         0: if (start) begin m_mode = 1; m_s = 0; m_first = 1; m_wait = 0; end
         1: begin
            if (abort) m_mode = 0;
            else if (m_first) begin m_first = 0; m_wait = 0; end
            else if (fin[step_unit[m_s]]) begin
               if (m_s == 39) m_mode = 2;
               else begin m_s++; m_first = 1; end
            end else begin
               m_wait++;
               if (m_wait == TIMEOUT) m_mode = 3;
            end
         end
         2: m_mode = 0;
         default: begin
            if (abort) m_mode = 0;
            else if (start) begin m_mode = 1; m_s = 0; m_first = 1; m_wait = 0; end
         end
      endcase
   endtask

   typedef struct packed {
      logic       rst, start, abort;
      logic [3:0] fin;
      logic [3:0] en;
      logic       busy, done, err;
      logic [3:0] round;
   } vec_t;

   function automatic vec_t mk(input logic r, input logic s, input logic a, input logic [3:0] f,
                               input logic [3:0] e, input logic b, input logic [3:0] rd);
      vec_t v;
      v.rst = r; v.start = s; v.abort = a; v.fin = f;
      v.en = e; v.busy = b; v.done = 1'b0; v.err = 1'b0; v.round = rd;
      return v;
   endfunction

   vec_t tbl [17];
   int   ncnt [4];
   int   ndone, done_at, c_issue, c_err, k;
   int   rq[$];
   int   last_r;
   bit   multi_en, skip_ok, mc10, last_sr10, found;
   logic [10:0] err_obs;

   initial begin
      k = 0;
      step_unit[k] = 3; step_round[k] = 0; k++;
      for (int r = 1; r <= 10; r++) begin
         step_unit[k] = 0; step_round[k] = r; k++;
         step_unit[k] = 1; step_round[k] = r; k++;
         if (r < 10) begin step_unit[k] = 2; step_round[k] = r; k++; end
         step_unit[k] = 3; step_round[k] = r; k++;
      end

      tbl[0]  = mk(1, 1, 0, 4'h0, 4'h0, 0, 4'd0);  // reset wins over start
      tbl[1]  = mk(0, 0, 0, 4'h0, 4'h0, 0, 4'd0);
      tbl[2]  = mk(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
      tbl[3]  = mk(0, 0, 0, 4'h8, 4'h8, 1, 4'd0);  // finished in issue cycle ignored
      tbl[4]  = mk(0, 0, 0, 4'h0, 4'h0, 1, 4'd0);
      tbl[5]  = mk(0, 1, 0, 4'h2, 4'h0, 1, 4'd0);  // stray sr finished, start while busy
      tbl[6]  = mk(0, 0, 0, 4'h8, 4'h0, 1, 4'd0);
      tbl[7]  = mk(0, 0, 0, 4'h1, 4'h1, 1, 4'd1);
      tbl[8]  = mk(0, 0, 0, 4'h2, 4'h0, 1, 4'd1);
      tbl[9]  = mk(0, 0, 0, 4'h1, 4'h0, 1, 4'd1);
      tbl[10] = mk(0, 1, 0, 4'h0, 4'h2, 1, 4'd1);
      tbl[11] = mk(0, 0, 1, 4'h0, 4'h0, 1, 4'd1);
      tbl[12] = mk(0, 0, 0, 4'h0, 4'h0, 0, 4'd0);
      tbl[13] = mk(0, 1, 0, 4'h0, 4'h0, 0, 4'd0);
      tbl[14] = mk(0, 0, 0, 4'h0, 4'h8, 1, 4'd0);
      tbl[15] = mk(0, 0, 1, 4'h0, 4'h0, 1, 4'd0);
      tbl[16] = mk(0, 0, 0, 4'h0, 4'h0, 0, 4'd0);

      rst = 1'b1; start = 1'b0; abort = 1'b0; man_fin = 4'h0; auto_resp = 1'b0; withhold = 1'b0;
      tick(); tick();

      for (int i = 0; i < 17; i++) begin
         rst = tbl[i].rst; start = tbl[i].start; abort = tbl[i].abort; man_fin = tbl[i].fin;
         @(negedge clk);
         check($sformatf("vec%0d", i), 32'(obs()),
               32'({tbl[i].en, tbl[i].busy, tbl[i].done, tbl[i].err, tbl[i].round}));
         tick();
      end
      rst = 1'b0; start = 1'b0; abort = 1'b0; man_fin = 4'h0;
      repeat (5) tick();

      // Full block with 3-cycle unit latency.
      auto_resp = 1'b1;
      for (int u = 0; u < 4; u++) ncnt[u] = 0;
      ndone = 0; done_at = -1; multi_en = 0; skip_ok = 0; mc10 = 0; last_sr10 = 0; last_r = -1;
      start = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if ($countones(en) > 1) multi_en = 1;
         for (int u = 0; u < 4; u++) if (en[u]) ncnt[u]++;
         if (done) begin ndone++; if (done_at < 0) done_at = n; end
         if (busy && int'(round) != last_r) begin rq.push_back(int'(round)); last_r = int'(round); end
         if (en[2] && round == 4'd10) mc10 = 1;
         if (en != 4'h0) begin
            if (last_sr10 && en == 4'h8) skip_ok = 1;
            last_sr10 = en[1] && (round == 4'd10);
         end
         tick();
         start = 1'b0;
      end
      check("done_count", 32'(ndone), 32'd1);
      check("done_cycle", 32'(done_at), 32'd161);
      check("ark_count", 32'(ncnt[3]), 32'd11);
      check("sb_count", 32'(ncnt[0]), 32'd10);
      check("sr_count", 32'(ncnt[1]), 32'd10);
      check("mc_count", 32'(ncnt[2]), 32'd9);
      check("one_hot_en", 32'(multi_en), 32'd0);
      check("r10_sr_then_ark", 32'(skip_ok), 32'd1);
      check("r10_no_mc", 32'(mc10), 32'd0);
      check("round_steps", 32'(rq.size()), 32'd11);
      for (int i = 0; i < 11; i++)
         check($sformatf("round_seq%0d", i), 32'((i < rq.size()) ? rq[i] : -1), 32'(i));

      // Timeout: sb finished withheld in round 2.
      withhold = 1'b1; c_issue = -1; c_err = -1; err_obs = '0;
      start = 1'b1;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (en[0] && round == 4'd2 && c_issue < 0) c_issue = n;
         if (err && c_err < 0) begin c_err = n; err_obs = obs(); end
         if (c_err >= 0 && n == c_err + 3) break;
         tick();
         start = 1'b0;
      end
      check("timeout_cycles", 32'(c_err - c_issue), 32'd64);
      check("err_entry", 32'(err_obs), 32'({4'h0, 1'b0, 1'b0, 1'b1, 4'd2}));
      check("err_held", 32'(obs()), 32'({4'h0, 1'b0, 1'b0, 1'b1, 4'd2}));
      tick();
      withhold = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("err_restart", 32'(obs()), 32'({4'h8, 1'b1, 1'b0, 1'b0, 4'd0}));
      tick();
      abort = 1'b1; tick(); abort = 1'b0;
      repeat (6) tick();

      // Reset held 2 cycles during round 4.
      found = 0;
      start = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (busy && round == 4'd4) begin found = 1; break; end
         tick();
         start = 1'b0;
      end
      check("reach_round4", 32'(found), 32'd1);
      tick(); start = 1'b0; tick();
      rst = 1'b1;
      tick();
      @(negedge clk);
      check("reset_outputs1", 32'(obs()), 32'd0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("reset_outputs2", 32'(obs()), 32'd0);
      ndone = 0;
      for (int n = 0; n < 250; n++) begin tick(); @(negedge clk); if (done) ndone++; end
      check("reset_no_done", 32'(ndone), 32'd0);
      tick();

      // Abort in round-5 MC wait, same cycle as mcols finished.
      found = 0;
      start = 1'b1;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk);
         if (en[2] && round == 4'd5) begin found = 1; break; end
         tick();
         start = 1'b0;
      end
      check("reach_mc_r5", 32'(found), 32'd1);
      tick(); start = 1'b0; tick(); tick();
      abort = 1'b1;
      @(negedge clk);
      check("abort_cycle_busy", 32'({busy, fin[2]}), 32'b11);
      tick();
      abort = 1'b0;
      @(negedge clk);
      check("abort_idle", 32'(obs()), 32'd0);
      ndone = 0;
      for (int n = 0; n < 200; n++) begin tick(); @(negedge clk); if (done) ndone++; end
      check("abort_no_done", 32'(ndone), 32'd0);
      tick();

      // Random traffic against the reference model.
      auto_resp = 1'b0;
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      m_mode = 0; m_s = 0; m_wait = 0; m_first = 0;
      for (int n = 0; n < 3500; n++) begin
         if (n < 2000) begin
            rst   = ($urandom_range(0, 149) == 0);
            abort = ($urandom_range(0, 39) == 0);
            for (int u = 0; u < 4; u++) man_fin[u] = ($urandom_range(0, 2) == 0);
         end else begin
            rst   = ($urandom_range(0, 999) == 0);
            abort = ($urandom_range(0, 399) == 0);
            for (int u = 0; u < 4; u++) man_fin[u] = ($urandom_range(0, 59) == 0);
         end
         start = ($urandom_range(0, 7) == 0);
         @(negedge clk);
         check($sformatf("random%0d", n), 32'(obs()), 32'(m_out()));
         m_step();
         tick();
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter: TIMEOUT, default 63, maximum number of wait cycles allowed for any sub-block's finished pulse.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to encrypt one 128-bit block; sampled in IDLE and ERR only.
REQ-005 abort  input  1  synchronous cancel of the operation in progress.
REQ-006 sbytes_enable / srows_enable / mcols_enable / ark_enable  output  1 each  single-cycle launch pulses to the SubBytes, ShiftRows, MixColumns and AddRoundKey units.
REQ-007 sbytes_finished / srows_finished / mcols_finished / ark_finished  input  1 each  completion pulses from those units.
REQ-008 round  output  4  current round index, 0..10; also the key-schedule select.
REQ-009 busy  output  1  high whenever state is not IDLE, DONE or ERR.
REQ-010 done  output  1  single-cycle pulse on completion of round 10.
REQ-011 err  output  1  timeout flag, held high while in ERR.

Function
REQ-012 States: IDLE, ARK0, SB, SR, MC, ARK, DONE, ERR.
REQ-013 Each step state (ARK0, SB, SR, MC, ARK) has two phases:
- Issue: the first cycle in the state; the matching enable is high for exactly this cycle.
- Wait: all following cycles, until the matching finished input is sampled high.
REQ-014 Finished inputs are ignored during the issue cycle, and any finished input other than the active unit's is ignored.
REQ-015 IDLE with start=1 goes to ARK0 next cycle, with round=0; ark_enable is high in the cycle after start.
REQ-016 ARK0 finished: round becomes 1, next state SB.
REQ-017 SB finished goes to SR.
REQ-018 SR finished goes to MC if round<10, else to ARK (MixColumns is skipped in round 10).
REQ-019 MC finished goes to ARK.
REQ-020 ARK finished: if round<10, round increments and the next state is SB; if round=10, the next state is DONE.
REQ-021 DONE: done=1 for one cycle, then IDLE; round returns to 0 on entering IDLE.
REQ-022 Wait counter: 7-bit, cleared on every issue cycle, incremented on each wait cycle without a finished pulse.
REQ-023 When the wait counter reaches TIMEOUT without a finished pulse, the next state is ERR.
REQ-024 ERR: err=1, no enables, round held; start=1 clears err and enters ARK0 with round=0.
REQ-025 abort=1 in any state other than IDLE forces IDLE next cycle:
- round=0;
- no done and no enable pulse in that cycle;
- abort has priority over finished and timeout in the same cycle.
REQ-026 start while busy or in DONE is ignored, with no queuing.
REQ-027 At most one enable output is high in any cycle.
REQ-028 Throughput: one block per 40 + sum of sub-block latencies cycles; no pipelining of blocks.

Reset
REQ-029 rst=1 at a clock edge forces state IDLE, with round=0, wait counter=0, all enables=0, busy=0, done=0, err=0.
REQ-030 Reset mid-operation discards the operation without a done pulse, and has priority over start and abort.
REQ-031 The first start is accepted in the cycle after rst deasserts.

Verification
REQ-032 Reset check: assert rst for 2 cycles mid-round 4 -> all outputs 0 the next cycle, and no done pulse afterwards.
REQ-033 Full block: unit models return finished 3 cycles after each enable; pulse start -> exactly one done, with ark_enable x11, sbytes_enable x10, srows_enable x10, mcols_enable x9, and round stepping 0,1,...,10.
REQ-034 Round-10 skip: when srows_finished arrives with round=10 -> the next enable is ark_enable, and mcols_enable is never issued.
REQ-035 Timeout: TIMEOUT=63, sbytes_finished withheld in round 2 -> err=1 and busy=0 after 63 wait cycles, round=2; a later start clears err and ark_enable pulses the next cycle.
REQ-036 Stray and early inputs: srows_finished pulsed during SB wait, and start pulsed while busy -> no state change and no extra enable; a finished pulse in the issue cycle is ignored.
REQ-037 Abort: abort pulsed during the MC wait of round 5, in the same cycle as mcols_finished -> IDLE next cycle, round=0, done never asserted.
